// File: rtl/distancer_from_28.sv
// Registered signed distance from bit 28 to the most significant set bit of a 64-bit word.
// Bits above 28 take precedence over bits below; bit 28 itself is never searched.
module distancer_from_28 #(
  parameter int REF_POS = 28,
  parameter int WIDTH   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] doubleWord,
  output logic [WIDTH-1:0] distance
);

  logic             upper_found;
  logic             lower_found;
  logic [WIDTH-1:0] upper_dist;
  logic [WIDTH-1:0] lower_dist;
  logic [WIDTH-1:0] next_distance;

  // Ascending scans: the last hit overwrites earlier ones, so the highest set bit wins.
  // Lower distances come out negative through two's-complement wraparound.
  always_comb begin
    upper_found = 1'b0;
    upper_dist  = '0;
    for (int unsigned i = REF_POS + 1; i < WIDTH; i++) begin
      if (doubleWord[i]) begin
        upper_found = 1'b1;
        upper_dist  = WIDTH'(i) - WIDTH'(REF_POS);
      end
    end

    lower_found = 1'b0;
    lower_dist  = '0;
    for (int unsigned j = 0; j < REF_POS; j++) begin
      if (doubleWord[j]) begin
        lower_found = 1'b1;
        lower_dist  = WIDTH'(j) - WIDTH'(REF_POS);
      end
    end
  end

  always_comb begin
    next_distance = '0;
    if (upper_found)
      next_distance = upper_dist;
    else if (lower_found)
      next_distance = lower_dist;
  end

  always_ff @(posedge clk) begin
    if (reset)
      distance <= '0;
    else
      distance <= next_distance;
  end

endmodule

// File: tb/tb_distancer_from_28.sv
// Directed self-checking bench for distancer_from_28 with hand-computed expected distances.
module tb_distancer_from_28;

  logic        clk;
  logic        reset;
  logic [63:0] doubleWord;
  logic [63:0] distance;

  int unsigned n_tests;
  int unsigned n_fail;

  distancer_from_28 dut (
    .clk        (clk),
    .reset      (reset),
    .doubleWord (doubleWord),
    .distance   (distance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Drive a word, let one rising edge pass, then sample just after it.
  task automatic apply(input string tag, input logic [63:0] w, input logic [63:0] exp);
    doubleWord = w;
    @(posedge clk);
    #1;
    check(tag, distance, exp);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    doubleWord = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", distance, 64'd0);
    reset = 1'b0;

    apply("upper_b35",    64'h0000_0008_1000_0000, 64'd7);
    apply("lower_b23",    64'h0000_0000_1080_0000, 64'hFFFF_FFFF_FFFF_FFFB);
    apply("only_b63",     64'h8000_0000_0000_0000, 64'd35);
    apply("only_b29",     64'h0000_0000_2000_0000, 64'd1);
    apply("only_b27",     64'h0000_0000_0800_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    apply("only_b0",      64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFE4);
    apply("b63_b0",       64'h8000_0000_0000_0001, 64'd35);
    apply("zero",         64'h0000_0000_0000_0000, 64'd0);
    apply("only_b28",     64'h0000_0000_1000_0000, 64'd0);
    apply("all_ones",     64'hFFFF_FFFF_FFFF_FFFF, 64'd35);
    apply("b40_low_mix",  64'h0000_0100_0FFF_FFFF, 64'd12);
    apply("b28_b0",       64'h0000_0000_1000_0001, 64'hFFFF_FFFF_FFFF_FFE4);
    apply("b30_b27",      64'h0000_0000_4800_0000, 64'd2);
    apply("b10_b3",       64'h0000_0000_0000_0408, 64'hFFFF_FFFF_FFFF_FFEE);

    // Reset priority over data, then recovery.
    apply("pre_reset",    64'h0000_0008_1000_0000, 64'd7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_prio", distance, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", distance, 64'd7);

    // Back-to-back words: output must lag input by exactly one edge.
    apply("pipe_first",   64'h0000_0000_1080_0000, 64'hFFFF_FFFF_FFFF_FFFB);
    doubleWord = 64'h0000_0008_1000_0000;
    #2;
    check("pipe_hold", distance, 64'hFFFF_FFFF_FFFF_FFFB);
    @(posedge clk);
    #1;
    check("pipe_second", distance, 64'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/distancer_from_28.md
Name: distancer_from_28

Overview:
- Registered leading-one distance unit for the floating-point ALU control path.
- Measures how far the most significant set bit of a 64-bit word lies from the reference position, bit 28.
- Bit 28 itself is excluded from the search.
- The signed result drives normalization shift decisions: positive means shift right, negative means shift left.

Parameters:
- REF_POS, 28, reference bit index; fixed in this block, not overridable in practice.
- WIDTH, 64, width of the input word and the output distance.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- doubleWord  input  64  word to analyse; treated as a raw bit vector.
- distance  output  64  signed two's-complement distance, registered.

Behaviour:
- Reset:
  - Reset is synchronous and active-high.
  - When reset is 1 at a rising clk edge, distance becomes 0.
  - Reset has priority over the data update on the same edge.
- Latency:
  - distance reflects the doubleWord sampled at the previous rising edge (1-cycle latency).
  - No handshake; a new word is accepted every cycle.
  - distance holds its value between edges.
- Search algorithm (combinational next-state):
  1. Upper search: find the highest index p in 63..29 with doubleWord[p]=1. If one exists, next distance = p − 28, in the range +1..+35.
  2. Lower search: only when no upper bit is set, find the highest index q in 27..0 with doubleWord[q]=1. If one exists, next distance = q − 28, in the range −28..−1.
  3. If no bit in 63..29 or 27..0 is set, next distance = 0. This holds regardless of bit 28.
- Bit 28 never influences the result.
- Upper-half bits always take precedence over lower bits, whatever the lower bits hold.
- Output format:
  - Full 64-bit signed two's complement, sign-extended.
  - Example: −5 = 0xFFFF_FFFF_FFFF_FFFB.
- No overflow is possible, since |distance| ≤ 35.
- Input X or Z bits need not be handled specially.
- Implementation: two priority encoders (35-bit and 28-bit) plus a subtract/select stage, feeding a 64-bit register.

Test Plan:
- Upper one: doubleWord with bits 35 and 28 set (0x0000_0008_1000_0000), one clk edge → distance = 7.
- Lower one: doubleWord with bits 28 and 23 set (0x0000_0000_1080_0000), one clk edge → distance = −5 (0xFFFF_FFFF_FFFF_FFFB).
- Extremes:
  - Only bit 63 set → 35.
  - Only bit 29 set → 1.
  - Only bit 27 set → −1.
  - Only bit 0 set → −28.
  - Bits 63 and 0 set → 35 (upper precedence).
- Null cases, each followed by one edge:
  - doubleWord = 0 → 0.
  - Only bit 28 set (0x0000_0000_1000_0000) → 0.
  - All ones → 35.
- Reset and latency:
  - With distance = 7, assert reset for one edge while doubleWord still has bit 35 set → distance = 0.
  - Deassert reset → 7 after the next edge.
  - Apply −5 and 7 stimuli on consecutive edges → outputs follow one cycle later in order.
